// File: rtl/xor_rr_sched.sv
// Round-robin scheduler sharing one registered XOR unit among NREQ requesters.
// Each op is granted, issued, sampled one cycle later and returned tagged with its id.
//
// state | meaning
// IDLE  | arbitrate; combinational one-hot grant to the first valid from ptr
// ISSUE | captured operands drive the XOR unit
// WAIT  | XOR unit result sampled into rsp_data/rsp_id
// RESP  | rsp_valid held until the consumer accepts
module xor_rr_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic [DW-1:0]      xu_a,
    output logic [DW-1:0]      xu_b,
    input  logic [DW-1:0]      xu_y,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_data,
    input  logic               rsp_ready,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] op_id_q;
    logic [DW-1:0]  op_a_q, op_b_q;
    logic [DW-1:0]  rsp_data_q;
    logic [IDW-1:0] rsp_id_q;

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW:0]   scan;
    logic           grant;

    // Search ptr, ptr+1, ... with wrap; the first valid index wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[scan[IDW-1:0]]) begin
                found = 1'b1;
                win   = scan[IDW-1:0];
            end
        end
    end

    assign ptr_nxt = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            op_id_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            if (grant) begin
                op_a_q  <= req_a[win*DW +: DW];
                op_b_q  <= req_b[win*DW +: DW];
                op_id_q <= win;
                ptr_q   <= ptr_nxt;
            end
            if (state_q == WAIT) begin
                rsp_data_q <= xu_y;
                rsp_id_q   <= op_id_q;
            end
        end
    end

    // Gated by rst so the grant cannot show while the block is held in reset.
    assign req_ready = (grant && rst) ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
    assign xu_a      = op_a_q;
    assign xu_b      = op_b_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_xor_rr_sched.sv
// Directed bench for xor_rr_sched with a registered XOR unit model.
// Expected grants, ids and XOR results are hand-computed constants.
module tb_xor_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [7:0]  xu_a, xu_b, xu_y;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    xor_rr_sched #(.NREQ(4), .DW(8), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .xu_a(xu_a), .xu_b(xu_b), .xu_y(xu_y),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared XOR unit: one-cycle registered result.
    always @(posedge clk or negedge rst) begin
        if (!rst) xu_y <= 8'h00;
        else      xu_y <= xu_a ^ xu_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant in IDLE, then ISSUE, WAIT, RESP (accepted immediately), back to IDLE.
    task automatic run_op(input string tag, input logic [3:0] vec, input logic [1:0] id,
                          input logic [7:0] data);
        req_valid = vec;
        rsp_ready = 1'b1;
        #1;
        check({tag, " grant"}, 32'(req_ready), 32'(4'b0001 << id));
        tick();
        check({tag, " ready_issue"}, 32'(req_ready), 32'h0);
        check({tag, " busy_issue"}, 32'(busy), 32'h1);
        tick();
        tick();
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h1);
        check({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
        check({tag, " rsp_data"}, 32'(rsp_data), 32'(data));
        tick();
        check({tag, " rsp_done"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 4'b0000;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst xu_a", 32'(xu_a), 32'h0);
        check("rst rsp_data", 32'(rsp_data), 32'h0);
        check("rst rsp_id", 32'(rsp_id), 32'h0);
        rst = 1'b1;
        tick();

        // single request: A5 ^ 0F = AA
        req_a = 32'h0000_00A5;
        req_b = 32'h0000_000F;
        req_valid = 4'b0001;
        #1;
        check("t1 grant", 32'(req_ready), 32'h1);
        check("t1 busy_idle", 32'(busy), 32'h0);
        tick();
        req_valid = 4'b0000;
        check("t1 xu_a", 32'(xu_a), 32'hA5);
        check("t1 xu_b", 32'(xu_b), 32'h0F);
        tick();
        check("t1 xu_a_wait", 32'(xu_a), 32'hA5);
        check("t1 rsp_valid_early", 32'(rsp_valid), 32'h0);
        tick();
        check("t1 rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1 rsp_data", 32'(rsp_data), 32'hAA);
        check("t1 rsp_id", 32'(rsp_id), 32'h0);
        tick();
        check("t1 idle", 32'(busy), 32'h0);

        // all four continuously valid, from ptr=0
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req_a = {8'h44, 8'h33, 8'h22, 8'h11};
        req_b = {8'hF0, 8'h0F, 8'hFF, 8'h01};
        run_op("t2 op0", 4'hF, 2'd0, 8'h10);
        run_op("t2 op1", 4'hF, 2'd1, 8'hDD);
        run_op("t2 op2", 4'hF, 2'd2, 8'h3C);
        run_op("t2 op3", 4'hF, 2'd3, 8'hB4);
        run_op("t2 op4", 4'hF, 2'd0, 8'h10);
        req_valid = 4'b0000;

        // backpressure on req2 (ptr=1)
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        check("t3 grant", 32'(req_ready), 32'h4);
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3 rsp_valid", 32'(rsp_valid), 32'h1);
            check("t3 rsp_data", 32'(rsp_data), 32'h3C);
            check("t3 rsp_id", 32'(rsp_id), 32'h2);
            check("t3 req_ready", 32'(req_ready), 32'h0);
            check("t3 busy", 32'(busy), 32'h1);
            tick();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        #1;
        check("t3 still_valid", 32'(rsp_valid), 32'h1);
        tick();
        check("t3 released", 32'(rsp_valid), 32'h0);
        check("t3 idle", 32'(busy), 32'h0);

        // pointer skip: grant req1 (ptr->2), then req3 before req0
        run_op("t4 r1", 4'b0010, 2'd1, 8'hDD);
        run_op("t4 r3", 4'b1001, 2'd3, 8'hB4);
        run_op("t4 r0", 4'b1001, 2'd0, 8'h10);
        req_valid = 4'b0000;

        // extremes on req0
        req_a[7:0] = 8'hFF;
        req_b[7:0] = 8'hFF;
        run_op("t6 ff_ff", 4'b0001, 2'd0, 8'h00);
        req_a[7:0] = 8'h00;
        run_op("t6 00_ff", 4'b0001, 2'd0, 8'hFF);
        req_valid = 4'b0000;

        // reset during WAIT of a req1 op
        req_valid = 4'b0010;
        #1;
        check("t5 grant", 32'(req_ready), 32'h2);
        tick();
        tick();
        check("t5 busy_wait", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check("t5 rst busy", 32'(busy), 32'h0);
        check("t5 rst rsp_valid", 32'(rsp_valid), 32'h0);
        check("t5 rst xu_a", 32'(xu_a), 32'h0);
        check("t5 rst xu_b", 32'(xu_b), 32'h0);
        check("t5 rst rsp_data", 32'(rsp_data), 32'h0);
        check("t5 rst rsp_id", 32'(rsp_id), 32'h0);
        check("t5 rst req_ready", 32'(req_ready), 32'h0);
        tick();
        tick();
        check("t5 no_rsp", 32'(rsp_valid), 32'h0);
        rst = 1'b1;
        run_op("t5 r0", 4'b0101, 2'd0, 8'hFF);
        run_op("t5 r2", 4'b0101, 2'd2, 8'h3C);
        req_valid = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
